// File: rtl/hbridge_dir_guard_if.sv
// Command and pin bundle between the PWM generator side and the H-bridge direction guard.
// The master drives the commands and reads back the pins and telemetry; the guard is the slave.
interface hbridge_dir_guard_if #(
   parameter int CNT_W = 16
);
   logic             pwm_in;
   logic             dir_in;
   logic             enable_in;
   logic             kill_in;
   logic             clear_in;
   logic             rpwm;
   logic             lpwm;
   logic             r_en;
   logic             l_en;
   logic             fault_out;
   logic [2:0]       state_out;
   logic [CNT_W-1:0] rev_count;

   modport master (
      output pwm_in, dir_in, enable_in, kill_in, clear_in,
      input  rpwm, lpwm, r_en, l_en, fault_out, state_out, rev_count
   );

   modport slave (
      input  pwm_in, dir_in, enable_in, kill_in, clear_in,
      output rpwm, lpwm, r_en, l_en, fault_out, state_out, rev_count
   );
endinterface

// File: rtl/hbridge_dir_guard.sv
// H-bridge output stage: steers single-ended PWM onto the R/L legs with dead time on
// start-up and every reversal, plus enable gating, latched kill and a reversal counter.
module hbridge_dir_guard #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int DEADTIME_CYC = 2000,
   parameter int CNT_W        = 16
) (
   input  logic               aclk,
   input  logic               rst_n,
   hbridge_dir_guard_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DEAD  = 3'd1,
      RUN_R = 3'd2,
      RUN_L = 3'd3,
      FAULT = 3'd4
   } state_t;

   localparam logic [15:0] DEAD_LOAD = 16'(DEADTIME_CYC - 1);

   state_t           state;
   state_t           next_state;
   logic [15:0]      dead_cnt;
   logic             load_dead;
   logic             rev_inc;
   logic [CNT_W-1:0] rev_q;
   logic             rpwm_d;
   logic             lpwm_d;
   logic             en_d;
   logic             fault_d;
   logic             rpwm_q;
   logic             lpwm_q;
   logic             r_en_q;
   logic             l_en_q;
   logic             fault_q;

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Kill outranks everything, then enable, then reversal detection, then dead-time expiry.
   always_comb begin
      next_state = state;
      load_dead  = 1'b0;
      rev_inc    = 1'b0;
      if (bus.kill_in) begin
         next_state = FAULT;
      end else if (state != FAULT && !bus.enable_in) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               next_state = DEAD;
               load_dead  = 1'b1;
            end
            DEAD: begin
               if (dead_cnt == 16'd0) begin
                  next_state = bus.dir_in ? RUN_R : RUN_L;
               end
            end
            RUN_R: begin
               if (!bus.dir_in) begin
                  next_state = DEAD;
                  load_dead  = 1'b1;
                  rev_inc    = 1'b1;
               end
            end
            RUN_L: begin
               if (bus.dir_in) begin
                  next_state = DEAD;
                  load_dead  = 1'b1;
                  rev_inc    = 1'b1;
               end
            end
            FAULT: begin
               if (bus.clear_in) begin
                  next_state = IDLE;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      rpwm_d  = (next_state == RUN_R) & bus.pwm_in;
      lpwm_d  = (next_state == RUN_L) & bus.pwm_in;
      en_d    = (next_state == DEAD) || (next_state == RUN_R) || (next_state == RUN_L);
      fault_d = (next_state == FAULT);
   end

   // Pins are registered from next_state so a kill or reversal clears the old leg on the same edge.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         rpwm_q  <= 1'b0;
         lpwm_q  <= 1'b0;
         r_en_q  <= 1'b0;
         l_en_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         rpwm_q  <= rpwm_d;
         lpwm_q  <= lpwm_d;
         r_en_q  <= en_d;
         l_en_q  <= en_d;
         fault_q <= fault_d;
      end
   end

   // Dead counter only reloads on entry, so dir toggles inside DEAD cannot stretch it.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         dead_cnt <= 16'd0;
      end else if (load_dead) begin
         dead_cnt <= DEAD_LOAD;
      end else if (state == DEAD && next_state == DEAD && dead_cnt != 16'd0) begin
         dead_cnt <= dead_cnt - 16'd1;
      end else if (next_state != DEAD) begin
         dead_cnt <= 16'd0;
      end
   end

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         rev_q <= '0;
      end else if (rev_inc && rev_q != {CNT_W{1'b1}}) begin
         rev_q <= rev_q + 1'b1;
      end
   end

   assign bus.rpwm      = rpwm_q;
   assign bus.lpwm      = lpwm_q;
   assign bus.r_en      = r_en_q;
   assign bus.l_en      = l_en_q;
   assign bus.fault_out = fault_q;
   assign bus.state_out = state;
   assign bus.rev_count = rev_q;

endmodule

// File: doc/hbridge_dir_guard.md
Name: hbridge_dir_guard

Overview:
- Downstream output stage between the PWM generator (single-ended pwm + dir) and the H-bridge driver pins (RPWM/LPWM/R_EN/L_EN).
- Replaces the combinational steering of PWM onto the two bridge legs.
- Inserts a programmable dead time on every direction reversal and at start-up.
- Provides enable gating, a latched kill/fault path and a saturating reversal counter for telemetry.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency; informational, not used in arithmetic.
- DEADTIME_CYC, 2000, number of cycles both PWM legs are held low on reversal or start-up; legal range 1..65535.
- CNT_W, 16, width of the reversal counter.

Ports:
- aclk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pwm_in  in  1  PWM from the generator; same clock domain.
- dir_in  in  1  direction from the generator; 1 = R leg, 0 = L leg.
- enable_in  in  1  run enable; 0 = bridge disabled.
- kill_in  in  1  emergency kill; level-sensitive, highest priority.
- clear_in  in  1  fault clear strobe.
- rpwm  out  1  R-leg PWM (registered).
- lpwm  out  1  L-leg PWM (registered).
- r_en  out  1  R-side driver enable (registered).
- l_en  out  1  L-side driver enable (registered).
- fault_out  out  1  1 while in FAULT.
- state_out  out  3  current state: IDLE=0, DEAD=1, RUN_R=2, RUN_L=3, FAULT=4.
- rev_count  out  CNT_W  number of direction reversals; saturating.

Behaviour:
Reset:
- Reset is asynchronous and active-low. It can be asserted at any time and takes effect immediately, mid-PWM or mid-DEAD included.
- Reset values: state=IDLE, rpwm=lpwm=0, r_en=l_en=0, fault_out=0, dead counter=0, rev_count=0.

Transition priority (evaluated every cycle, highest first):
1. kill_in=1 -> FAULT, from any state.
2. enable_in=0 -> IDLE, from any state except FAULT.
3. Direction mismatch in a RUN state -> DEAD.
4. Dead counter expiry.

State rules:
- IDLE: when enable_in=1 and kill_in=0 -> DEAD; dead counter loaded with DEADTIME_CYC-1.
- DEAD:
  - Counter decrements each cycle.
  - At counter==0 -> RUN_R if dir_in=1, else RUN_L. dir_in is sampled on that exit cycle only.
  - DEAD therefore lasts exactly DEADTIME_CYC cycles.
  - dir_in toggling inside DEAD does not restart the counter.
- RUN_R: if dir_in=0 -> DEAD (counter reloaded) and rev_count increments.
- RUN_L: if dir_in=1 -> DEAD (counter reloaded) and rev_count increments.
- FAULT: exits to IDLE only when clear_in=1 and kill_in=0 on the same cycle. clear_in while kill_in=1 is ignored.

Outputs (all registered from next_state, one clock after the inputs are sampled):
- rpwm <= (next_state==RUN_R) & pwm_in.
- lpwm <= (next_state==RUN_L) & pwm_in.
- r_en and l_en <= next_state is DEAD, RUN_R or RUN_L.
- fault_out <= next_state==FAULT.
- state_out reflects the current state register.

Invariants:
- rpwm and lpwm are never both 1.
- After a reversal, the newly active leg stays low for at least DEADTIME_CYC cycles after the old leg drops.
- Pulses narrower than one cycle cannot occur (synchronous input).

rev_count:
- Increments only on RUN->DEAD transitions caused by a direction change, not on start-up.
- Saturates at all-ones; no wrap.
- Cleared only by reset.

Timing:
- Latency from pwm_in to rpwm/lpwm is 1 cycle in a RUN state.
- A kill sampled at edge n forces all outputs to 0 at edge n.

Test Plan:
1. Reset released, enable_in=1, dir_in=1, pwm_in toggling, DEADTIME_CYC=4 -> state_out 1 for 4 cycles, then 2; rpwm follows pwm_in with 1-cycle lag; lpwm=0; r_en=l_en=1 from the first DEAD cycle.
2. In RUN_R, dir_in 1->0 at cycle n -> rpwm=0 from edge n; lpwm held 0 for 4 cycles; lpwm follows pwm_in from edge n+4; rev_count=1.
3. Toggle dir_in every cycle during DEAD -> DEAD still exits after exactly 4 cycles into the leg given by dir_in on the exit cycle; rev_count unchanged.
4. kill_in pulsed high for 1 cycle in RUN_L -> all outputs 0, fault_out=1. clear_in while kill_in=1 -> stays FAULT. Then clear_in with kill_in=0 -> IDLE, en=0; with enable_in=1 -> a new DEAD of 4 cycles.
5. enable_in dropped mid-DEAD -> IDLE next edge, all outputs 0. Re-enable -> full 4-cycle DEAD, not the remainder.
6. CNT_W=3, 9 reversals -> rev_count saturates at 7. Assert rst_n low mid-run -> outputs 0 immediately, without waiting for a clock edge.
